wb_arbiter2: RTL and testbench

WB_ARBITER2 -- requirements
Module: wb_arbiter2

---
 rtl/wb_arbiter2_if.sv | 19 +
 rtl/wb_arbiter2.sv | 115 +++++++++++
 tb/tb_wb_arbiter2.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter2_if.sv
// rtl/wb_arbiter2_if.sv - Wishbone link bundle between one bus master and one bus slave
// Master -> slave : cyc, stb, we, adr[31:0], sel[3:0], dat_w[31:0]
// Slave -> master : dat_r[31:0], ack, err
// modport master  : the side that issues cycles
// modport slave   : the side that answers cycles
interface wb_arbiter2_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;
  logic        err;

  modport master (output cyc, stb, we, adr, sel, dat_w, input dat_r, ack, err);
  modport slave  (input cyc, stb, we, adr, sel, dat_w, output dat_r, ack, err);
endinterface

// File: rtl/wb_arbiter2.sv
// rtl/wb_arbiter2.sv - two-master round-robin Wishbone arbiter with stall timeout
// clk_i, rst_i : clock, synchronous active-high reset
// m0_bus       : master 0 (instruction bus), slave side of the link
// m1_bus       : master 1 (data bus), slave side of the link
// dn_bus       : downstream Wishbone port, master side of the link (err unused)
// gnt_o        : one-hot registered grant, 2'b00 when idle
// timeout_o    : one-cycle pulse alongside any master err
module wb_arbiter2 #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk_i,
  input  logic          rst_i,
  wb_arbiter2_if.slave  m0_bus,
  wb_arbiter2_if.slave  m1_bus,
  wb_arbiter2_if.master dn_bus,
  output logic [1:0]    gnt_o,
  output logic          timeout_o
);

  localparam logic [15:0] STALL_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        lw_q, lw_d;        // last winner: 0 = m0, 1 = m1
  logic [15:0] stall_q, stall_d;
  logic        kill_q, kill_d;    // suppresses stb for the cycle after a timeout

  logic g0, g1, stb_w, hit;
  logic unused_dn_err;

  assign g0 = (state_q == GNT0);
  assign g1 = (state_q == GNT1);

  // Downstream port follows the granted master; everything is zero in IDLE.
  assign dn_bus.cyc   = (g0 & m0_bus.cyc) | (g1 & m1_bus.cyc);
  assign stb_w        = ((g0 & m0_bus.cyc & m0_bus.stb) |
                         (g1 & m1_bus.cyc & m1_bus.stb)) & ~kill_q;
  assign dn_bus.stb   = stb_w;
  assign dn_bus.we    = (g0 & m0_bus.we) | (g1 & m1_bus.we);
  assign dn_bus.adr   = ({32{g0}} & m0_bus.adr)   | ({32{g1}} & m1_bus.adr);
  assign dn_bus.sel   = ({4{g0}}  & m0_bus.sel)   | ({4{g1}}  & m1_bus.sel);
  assign dn_bus.dat_w = ({32{g0}} & m0_bus.dat_w) | ({32{g1}} & m1_bus.dat_w);

  // Timeout fires on the last allowed stall cycle; an ack in that cycle wins.
  assign hit = stb_w & ~dn_bus.ack & (stall_q == STALL_LAST);

  assign m0_bus.dat_r = dn_bus.dat_r;
  assign m1_bus.dat_r = dn_bus.dat_r;
  assign m0_bus.ack   = g0 & dn_bus.ack;
  assign m1_bus.ack   = g1 & dn_bus.ack;
  assign m0_bus.err   = g0 & hit;
  assign m1_bus.err   = g1 & hit;
  assign timeout_o    = hit;
  assign gnt_o        = {g1, g0};

  assign unused_dn_err = dn_bus.err;

  always_comb begin
    state_d = state_q;
    lw_d    = lw_q;
    case (state_q)
      IDLE: begin
        if (m0_bus.cyc && m1_bus.cyc) begin
          state_d = lw_q ? GNT0 : GNT1;
        end else if (m0_bus.cyc) begin
          state_d = GNT0;
        end else if (m1_bus.cyc) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        if (!m0_bus.cyc) begin
          state_d = IDLE;
          lw_d    = 1'b0;
        end
      end
      GNT1: begin
        if (!m1_bus.cyc) begin
          state_d = IDLE;
          lw_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // stb_w is already 0 in IDLE, so the counter clears there too.
  always_comb begin
    stall_d = stall_q + 16'd1;
    if (!stb_w || dn_bus.ack || hit) begin
      stall_d = 16'd0;
    end
    kill_d = hit;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      lw_q    <= 1'b1;
      stall_q <= 16'd0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lw_q    <= lw_d;
      stall_q <= stall_d;
      kill_q  <= kill_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// tb/tb_wb_arbiter2.sv - self-checking bench for wb_arbiter2 against a behavioural model
module tb_wb_arbiter2;
  localparam int TOUT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] gnt;
  logic       tout;

  wb_arbiter2_if m0_if ();
  wb_arbiter2_if m1_if ();
  wb_arbiter2_if dn_if ();

  wb_arbiter2 #(.TIMEOUT(TOUT)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .m0_bus    (m0_if),
    .m1_bus    (m1_if),
    .dn_bus    (dn_if),
    .gnt_o     (gnt),
    .timeout_o (tout)
  );

  always #5 clk = ~clk;

  // stimulus state, indexed by master
  logic        mc[2], ms[2], mw[2];
  logic [31:0] ma[2], md[2];
  logic [3:0]  mse[2];
  logic        sack;
  logic [31:0] sdat;

  // reference model: owner 0 = nobody, 1 = m0, 2 = m1
  int owner;
  int last;
  int stalls;
  bit kill;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    m0_if.cyc = mc[0]; m0_if.stb = ms[0]; m0_if.we = mw[0];
    m0_if.adr = ma[0]; m0_if.sel = mse[0]; m0_if.dat_w = md[0];
    m1_if.cyc = mc[1]; m1_if.stb = ms[1]; m1_if.we = mw[1];
    m1_if.adr = ma[1]; m1_if.sel = mse[1]; m1_if.dat_w = md[1];
    dn_if.ack = sack; dn_if.dat_r = sdat; dn_if.err = 1'b0;
  endtask

  task automatic clear_inputs();
    for (int m = 0; m < 2; m++) begin
      mc[m] = 0; ms[m] = 0; mw[m] = 0; ma[m] = '0; md[m] = '0; mse[m] = '0;
    end
    sack = 0; sdat = '0; rst = 0;
  endtask

  task automatic model_reset();
    owner = 0; last = 1; stalls = 0; kill = 0;
  endtask

  // One clock: check every output at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    int          i;
    logic        e_cyc, e_stb, e_we, hit;
    logic [31:0] e_adr, e_dat;
    logic [3:0]  e_sel;
    logic [1:0]  e_gnt;
    drive();
    @(negedge clk);
    e_cyc = 0; e_stb = 0; e_we = 0; e_adr = '0; e_sel = '0; e_dat = '0;
    if (owner != 0) begin
      i = owner - 1;
      e_cyc = mc[i]; e_stb = mc[i] && ms[i] && !kill; e_we = mw[i];
      e_adr = ma[i]; e_sel = mse[i]; e_dat = md[i];
    end
    hit   = e_stb && !sack && (stalls == TOUT - 1);
    e_gnt = (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00;
    check("gnt",     32'(gnt),          32'(e_gnt));
    check("cyc_o",   32'(dn_if.cyc),    32'(e_cyc));
    check("stb_o",   32'(dn_if.stb),    32'(e_stb));
    check("we_o",    32'(dn_if.we),     32'(e_we));
    check("adr_o",   dn_if.adr,         e_adr);
    check("sel_o",   32'(dn_if.sel),    32'(e_sel));
    check("dat_o",   dn_if.dat_w,       e_dat);
    check("m0_ack",  32'(m0_if.ack),    32'(owner == 1 && sack));
    check("m1_ack",  32'(m1_if.ack),    32'(owner == 2 && sack));
    check("m0_err",  32'(m0_if.err),    32'(owner == 1 && hit));
    check("m1_err",  32'(m1_if.err),    32'(owner == 2 && hit));
    check("timeout", 32'(tout),         32'(hit));
    check("m0_dat",  m0_if.dat_r,       sdat);
    check("m1_dat",  m1_if.dat_r,       sdat);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      stalls = (e_stb && !sack && !hit) ? stalls + 1 : 0;
      kill   = hit;
      if (owner == 0) begin
        if (mc[0] && mc[1]) owner = (last == 0) ? 2 : 1;
        else if (mc[0])     owner = 1;
        else if (mc[1])     owner = 2;
      end else if (!mc[owner - 1]) begin
        last  = owner - 1;
        owner = 0;
      end
    end
    #1;
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 0;

    // reset state
    drive();
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_cyc", 32'(dn_if.cyc), 32'd0);
    cycle();

    // tie after reset: m0 first, then m1 after one idle cycle
    mc[0] = 1; ms[0] = 1; mc[1] = 1; ms[1] = 1;
    cycle();
    check("tie_m0_first", 32'(gnt), 32'b01);
    sack = 1; cycle(); sack = 0;
    mc[0] = 0; ms[0] = 0;
    cycle();
    check("handover_idle", 32'(gnt), 32'b00);
    cycle();
    check("m1_not_starved", 32'(gnt), 32'b10);

    // m1 holds cyc across three strobes while m0 waits
    mc[0] = 1; ms[0] = 1;
    for (int k = 0; k < 3; k++) begin
      ma[1] = 32'h0000_1000 + 32'(4 * k); sack = 1;
      drive(); #1;
      check("m1_block_ack", 32'(m1_if.ack), 32'd1);
      cycle();
      check("m1_hold", 32'(gnt), 32'b10);
    end
    sack = 0; mc[1] = 0; ms[1] = 0;
    cycle();
    check("release_idle", 32'(gnt), 32'b00);
    cycle();
    check("m0_after_m1", 32'(gnt), 32'b01);

    // m0 read with data return
    ma[0] = 32'h0000_0040; mw[0] = 0; sack = 1; sdat = 32'hDEAD_BEEF;
    drive(); #1;
    check("rd_m0_ack", 32'(m0_if.ack), 32'd1);
    check("rd_m0_dat", m0_if.dat_r, 32'hDEAD_BEEF);
    check("rd_m1_ack", 32'(m1_if.ack), 32'd0);
    cycle();
    sack = 0; mc[0] = 0; ms[0] = 0;
    cycle();

    // timeout on m1
    mc[1] = 1; ms[1] = 1;
    cycle();
    for (int s = 1; s <= TOUT; s++) begin
      drive(); #1;
      check("to_m1_err", 32'(m1_if.err), 32'(s == TOUT));
      check("to_pulse",  32'(tout),      32'(s == TOUT));
      cycle();
    end
    check("to_stb_low", 32'(dn_if.stb), 32'd0);
    cycle();

    // ack on the last stall cycle wins over the timeout
    for (int s = 1; s < TOUT; s++) cycle();
    sack = 1;
    drive(); #1;
    check("late_ack",     32'(m1_if.ack), 32'd1);
    check("late_no_err",  32'(m1_if.err), 32'd0);
    check("late_no_tout", 32'(tout),      32'd0);
    cycle();
    sack = 0; mc[1] = 0; ms[1] = 0;
    cycle();

    // m0 short cycle so m0 is last winner, then reset mid-write
    mc[0] = 1; ms[0] = 1; sack = 1;
    cycle(); cycle();
    sack = 0; mc[0] = 0; ms[0] = 0;
    cycle(); cycle();
    mc[0] = 1; ms[0] = 1; mw[0] = 1; ma[0] = 32'h0000_0200; md[0] = 32'h1234_5678; mse[0] = 4'hF;
    cycle();
    check("wr_stb", 32'(dn_if.stb), 32'd1);
    rst = 1;
    cycle();
    rst = 0;
    drive(); #1;
    check("rst_abort_cyc", 32'(dn_if.cyc), 32'd0);
    check("rst_abort_gnt", 32'(gnt),       32'd0);
    check("rst_abort_ack", 32'(m0_if.ack | m0_if.err | m1_if.ack | m1_if.err), 32'd0);
    mc[1] = 1; ms[1] = 1;
    cycle();
    check("rst_tie_m0", 32'(gnt), 32'b01);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      for (int m = 0; m < 2; m++) begin
        if (mc[m]) begin
          if ($urandom_range(0, 5) == 0) begin
            mc[m] = 0; ms[m] = 0;
          end else begin
            ms[m] = ($urandom_range(0, 9) < 7);
          end
        end else if ($urandom_range(0, 9) < 4) begin
          mc[m] = 1; ms[m] = 1;
        end
        mw[m]  = 1'($urandom);
        ma[m]  = $urandom;
        md[m]  = $urandom;
        mse[m] = 4'($urandom);
      end
      sack = ($urandom_range(0, 99) < 35);
      sdat = $urandom;
      rst  = ($urandom_range(0, 299) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
